// File: rtl/d7s_pkg.sv
// Shared seven-segment definitions: the encoder pattern table, the blank
// pattern and the capture FSM state type.
package d7s_pkg;

  // Segment patterns, active-high, bit6=g .. bit0=a; entry i displays hex digit i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h27, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } cap_state_t;

endpackage

// File: rtl/d7s_seg_decode.sv
// Inverse of the display encoder table: active-high segment pattern to
// nibble, with blank and bad (not-in-table) flags.
module d7s_seg_decode
  import d7s_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_blank,
  output logic       o_bad
);

  // NOTE: every output gets a default before any condition, so no path can infer a latch.
  always_comb begin
    o_nibble = 4'h0;
    o_blank  = 1'b0;
    o_bad    = 1'b1;
    if (i_seg == SEG_BLANK) begin
      o_blank = 1'b1;
      o_bad   = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (i_seg == SEG_TABLE[i]) begin
          o_nibble = 4'(i);
          o_bad    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/d7s_capture.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus and hands
// complete frames out over valid/ready. Optional decimal point: D7S_CAPTURE_DP_EN.
module d7s_capture
  import d7s_pkg::*;
#(
  parameter int NDIGITS       = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           seg_n,
  input  logic [NDIGITS-1:0]   dig_n,
`ifdef D7S_CAPTURE_DP_EN
  input  logic                 dp_n,
  output logic [NDIGITS-1:0]   dp,
`endif
  output logic [4*NDIGITS-1:0] digits,
  output logic [NDIGITS-1:0]   blank,
  output logic [NDIGITS-1:0]   bad,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);

`ifdef D7S_CAPTURE_DP_EN
  localparam int SW = NDIGITS + 8;
`else
  localparam int SW = NDIGITS + 7;
`endif
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 2);

  logic [SW-1:0]        w_sample, r_sync1, r_sync2, r_prev;
  logic [CW-1:0]        r_cnt;
  logic                 w_same, w_cap;
  logic [NDIGITS-1:0]   w_sel, w_cap_mask, r_seen, w_seen_nxt;
  logic                 w_onehot, w_all_seen;
  logic [3:0]           w_nib;
  logic                 w_blank, w_bad;
  logic [4*NDIGITS-1:0] r_stg_nib, w_stg_nib_nxt, r_digits;
  logic [NDIGITS-1:0]   r_stg_blank, w_stg_blank_nxt, r_blank;
  logic [NDIGITS-1:0]   r_stg_bad, w_stg_bad_nxt, r_bad;
  logic                 r_overrun;
  cap_state_t           r_state, w_state_nxt;
  logic                 w_publish, w_discard;

`ifdef D7S_CAPTURE_DP_EN
  logic [NDIGITS-1:0]   r_stg_dp, w_stg_dp_nxt, r_dp;
  assign w_sample = {dp_n, dig_n, seg_n};
`else
  assign w_sample = {dig_n, seg_n};
`endif

  // Capture fires once, on the cycle the run of identical samples reaches STABLE_CYCLES.
  assign w_same = (r_sync2 == r_prev);
  assign w_cap  = w_same && (r_cnt == CNT_CAP);

  assign w_sel      = ~r_sync2[NDIGITS+6:7];
  assign w_onehot   = (w_sel != '0) && ((w_sel & (w_sel - NDIGITS'(1))) == '0);
  assign w_cap_mask = (w_cap && w_onehot) ? w_sel : '0;
  assign w_seen_nxt = r_seen | w_cap_mask;
  assign w_all_seen = &w_seen_nxt;

  d7s_seg_decode u_decode (
    .i_seg    (~r_sync2[6:0]),
    .o_nibble (w_nib),
    .o_blank  (w_blank),
    .o_bad    (w_bad)
  );

  always_comb begin
    w_stg_nib_nxt   = r_stg_nib;
    w_stg_blank_nxt = r_stg_blank;
    w_stg_bad_nxt   = r_stg_bad;
`ifdef D7S_CAPTURE_DP_EN
    w_stg_dp_nxt    = r_stg_dp;
`endif
    for (int i = 0; i < NDIGITS; i++) begin
      if (w_cap_mask[i]) begin
        w_stg_nib_nxt[4*i +: 4] = w_nib;
        w_stg_blank_nxt[i]      = w_blank;
        w_stg_bad_nxt[i]        = w_bad;
`ifdef D7S_CAPTURE_DP_EN
        w_stg_dp_nxt[i]         = ~r_sync2[SW-1];
`endif
      end
    end
  end

  // A handshake takes priority over a completed frame in HOLD; seen is kept for COLLECT.
  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    w_discard   = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_all_seen) begin
          w_publish   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = COLLECT;
        end else if (w_all_seen) begin
          w_discard = 1'b1;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_prev      <= '0;
      r_cnt       <= '0;
      r_seen      <= '0;
      r_stg_nib   <= '0;
      r_stg_blank <= '0;
      r_stg_bad   <= '0;
      r_digits    <= '0;
      r_blank     <= '0;
      r_bad       <= '0;
      r_overrun   <= 1'b0;
      r_state     <= COLLECT;
    end else begin
      r_sync1     <= w_sample;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      if (!w_same)               r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
      r_seen      <= (w_publish || w_discard) ? '0 : w_seen_nxt;
      r_stg_nib   <= w_stg_nib_nxt;
      r_stg_blank <= w_stg_blank_nxt;
      r_stg_bad   <= w_stg_bad_nxt;
      if (w_publish) begin
        r_digits <= w_stg_nib_nxt;
        r_blank  <= w_stg_blank_nxt;
        r_bad    <= w_stg_bad_nxt;
      end
      if (w_discard) r_overrun <= 1'b1;
      r_state     <= w_state_nxt;
    end
  end

`ifdef D7S_CAPTURE_DP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_dp <= '0;
      r_dp     <= '0;
    end else begin
      r_stg_dp <= w_stg_dp_nxt;
      if (w_publish) r_dp <= w_stg_dp_nxt;
    end
  end
  assign dp = r_dp;
`endif

  assign digits    = r_digits;
  assign blank     = r_blank;
  assign bad       = r_bad;
  assign overrun   = r_overrun;
  assign out_valid = (r_state == HOLD);

endmodule
